// File: rtl/sar_avg_pkg.sv
// sar_avg_pkg: shared definitions for the SAR result averager.
//   state_e       controller states (IDLE, WAIT, CONV)
//   SEQ_LSB/SEQ_W position and width of the push sequence tag in DOUT
//   LOST_BIT      DOUT bit flagging dropped words before this one
//   WORD_W        FIFO word width
//   TIMEOUT_LIMIT / WD_W  conversion watchdog limit and counter width
package sar_avg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CONV = 2'd2
  } state_e;

  localparam int unsigned WORD_W        = 16;
  localparam int unsigned SEQ_LSB       = 8;
  localparam int unsigned SEQ_W         = 4;
  localparam int unsigned LOST_BIT      = 12;
  localparam int unsigned TIMEOUT_LIMIT = 1023;
  localparam int unsigned WD_W          = 10;

endpackage

// File: rtl/sar_result_avg_if.sv
// sar_result_avg_if: ADC handshake and FIFO read-side signals.
//   GO      conversion start pulse to the ADC
//   VALID   ADC conversion done, RESULT  ADC code
//   POP     read strobe, DOUT head word, EMPTY/FULL/LEVEL FIFO status
// master: the averager; slave: ADC + SPI side.
interface sar_result_avg_if #(
  parameter int unsigned RES_W      = 5,
  parameter int unsigned FIFO_DEPTH = 4
);
  logic                          GO;
  logic                          VALID;
  logic [RES_W-1:0]              RESULT;
  logic                          POP;
  logic [15:0]                   DOUT;
  logic                          EMPTY;
  logic                          FULL;
  logic [$clog2(FIFO_DEPTH):0]   LEVEL;

  modport master (output GO, input VALID, input RESULT,
                  input POP, output DOUT, output EMPTY, output FULL, output LEVEL);
  modport slave  (input GO, output VALID, output RESULT,
                  output POP, input DOUT, input EMPTY, input FULL, input LEVEL);
endinterface

// File: rtl/sar_result_fifo.sv
// sar_result_fifo: synchronous first-word-fall-through FIFO.
//   CLK, RSTN   clock, synchronous active-low reset (flushes)
//   push, din   write request and data (ignored when full unless popping)
//   pop         read request (ignored when empty)
//   dout        head word, 0 when empty
//   empty, full, level  occupancy status, registered
module sar_result_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [LVL_W-1:0] r_level;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty     = (r_level == '0);
  assign full      = (r_level == LVL_W'(DEPTH));
  assign level     = r_level;
  assign dout      = empty ? '0 : r_mem[r_rd];
  assign w_do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO still takes the push.
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge CLK) begin
    if (w_do_push) r_mem[r_wr] <= din;
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + PTR_W'(1);
      if (w_do_pop)  r_rd <= r_rd + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

// File: rtl/sar_result_avg.sv
// sar_result_avg: SAR ADC trigger/averager with tagged result FIFO.
//   CLK, RSTN  clock, synchronous active-low reset
//   EN         auto-trigger run enable
//   PERIOD     idle cycles between an accepted VALID and the next GO
//   bus        ADC handshake (GO/VALID/RESULT) and FIFO read side
//              (POP/DOUT/EMPTY/FULL/LEVEL)
//   OVF        sticky: a word was dropped on a full FIFO
//   TIMEOUT    sticky conversion watchdog flag
// Optional: define SAR_VALID_TIMEOUT_EN to abort a conversion that sees
// no VALID edge within TIMEOUT_LIMIT cycles; otherwise TIMEOUT is 0.
module sar_result_avg
  import sar_avg_pkg::*;
#(
  parameter int unsigned RES_W      = 5,
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PERIOD_W   = 8
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                EN,
  input  logic [PERIOD_W-1:0] PERIOD,
  sar_result_avg_if.master    bus,
  output logic                OVF,
  output logic                TIMEOUT
);
  localparam int unsigned ACC_W = RES_W + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(2 ** AVG_LOG2);

  state_e              r_state;
  logic [PERIOD_W-1:0] r_timer;
  logic                r_valid_q;
  logic [ACC_W-1:0]    r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic [SEQ_W-1:0]    r_seq;
  logic                r_lost;
  logic                r_ovf;

  logic                w_accept;
  logic                w_conv_accept;
  logic                w_start;
  logic                w_wd_expire;
  logic                w_push;
  logic                w_pop_ok;
  logic                w_store;
  logic                w_drop;
  logic [RES_W-1:0]    w_avg;
  logic [WORD_W-1:0]   w_word;

  assign w_accept      = bus.VALID && !r_valid_q;
  assign w_conv_accept = w_accept && (r_state == CONV);
  assign w_start       = (r_state == IDLE) && EN;
  assign bus.GO        = (r_state == WAIT) && EN && (r_timer == '0);
  // Count reaching the full set one cycle after the last accept triggers the push.
  assign w_push        = (r_cnt == CNT_FULL);
  assign w_pop_ok      = bus.POP && !bus.EMPTY;
  assign w_store       = w_push && (!bus.FULL || w_pop_ok);
  assign w_drop        = w_push && !w_store;
  assign w_avg         = RES_W'(r_acc >> AVG_LOG2);
  assign OVF           = r_ovf;

  always_comb begin
    w_word                    = '0;
    w_word[RES_W-1:0]         = w_avg;
    w_word[SEQ_LSB +: SEQ_W]  = r_seq;
    w_word[LOST_BIT]          = r_lost;
  end

`ifdef SAR_VALID_TIMEOUT_EN
  logic [WD_W-1:0] r_wd;
  logic            r_timeout;

  assign w_wd_expire = (r_state == CONV) && !w_accept &&
                       (r_wd == WD_W'(TIMEOUT_LIMIT - 1));
  assign TIMEOUT     = r_timeout;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wd <= (r_state == CONV) ? r_wd + WD_W'(1) : '0;
      if (w_wd_expire)  r_timeout <= 1'b1;
      else if (w_start) r_timeout <= 1'b0;
    end
  end
`else
  assign w_wd_expire = 1'b0;
  assign TIMEOUT     = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_valid_q <= 1'b0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_seq     <= '0;
      r_lost    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_valid_q <= bus.VALID;

      case (r_state)
        IDLE: if (EN) begin
          r_state <= WAIT;
          r_timer <= PERIOD;
          r_ovf   <= 1'b0;
        end
        WAIT: begin
          if (!EN)                  r_state <= IDLE;
          else if (r_timer == '0)   r_state <= CONV;
          else                      r_timer <= r_timer - PERIOD_W'(1);
        end
        CONV: if (w_accept || w_wd_expire) begin
          r_state <= EN ? WAIT : IDLE;
          r_timer <= PERIOD;
        end
        default: r_state <= IDLE;
      endcase

      if (w_push) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_seq <= r_seq + SEQ_W'(1);
      end else if (w_conv_accept) begin
        r_acc <= r_acc + ACC_W'(bus.RESULT);
        r_cnt <= r_cnt + CNT_W'(1);
      end

      // Drop is evaluated after the IDLE exit clear so a coincident drop still flags.
      if (w_drop) begin
        r_ovf  <= 1'b1;
        r_lost <= 1'b1;
      end else if (w_store) begin
        r_lost <= 1'b0;
      end
    end
  end

  sar_result_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .push  (w_store),
    .din   (w_word),
    .pop   (bus.POP),
    .dout  (bus.DOUT),
    .empty (bus.EMPTY),
    .full  (bus.FULL),
    .level (bus.LEVEL)
  );
endmodule

// File: tb/tb_sar_result_avg.sv
`timescale 1ns/1ps
module tb_sar_result_avg;
  localparam int unsigned RES_W      = 5;
  localparam int unsigned AVG_LOG2   = 2;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned PERIOD_W   = 8;
  localparam int          NAVG       = 1 << AVG_LOG2;

  logic                clk = 1'b0;
  logic                rstn;
  logic                en;
  logic [PERIOD_W-1:0] period;
  logic                ovf;
  logic                timeout;

  always #5 clk = ~clk;

  sar_result_avg_if #(.RES_W(RES_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  sar_result_avg #(
    .RES_W      (RES_W),
    .AVG_LOG2   (AVG_LOG2),
    .FIFO_DEPTH (FIFO_DEPTH),
    .PERIOD_W   (PERIOD_W)
  ) dut (
    .CLK     (clk),
    .RSTN    (rstn),
    .EN      (en),
    .PERIOD  (period),
    .bus     (bus),
    .OVF     (ovf),
    .TIMEOUT (timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // ADC responder configuration and bookkeeping
  int adc_vals[4];
  int adc_n      = 1;
  int adc_idx    = 0;
  int adc_lat    = 0;
  int adc_hold   = 1;
  int adc_left   = 0;
  int go_pending = 0;
  int go_total   = 0;
  int valid_cyc  = -1;
  int last_go_cyc = 0;
  logic go_prev = 1'b0;
  logic cmp_en  = 1'b0;

  // Reference model: FIFO contents as a queue of expected words
  logic [15:0] q[$];
  int          m_sum, m_n, m_pavg;
  logic [3:0]  m_seq;
  logic        m_lost, m_ovf, m_pend, m_vprev, m_enprev;

  always @(posedge clk) begin
    if (!rstn) begin
      q.delete();
      m_sum = 0; m_n = 0; m_pavg = 0; m_seq = 0;
      m_lost = 0; m_ovf = 0; m_pend = 0; m_vprev = 0; m_enprev = 1;
    end else begin
      if (en && !m_enprev) m_ovf = 0;
      if (bus.POP && q.size() > 0) void'(q.pop_front());
      if (m_pend) begin
        m_pend = 0;
        if (q.size() < FIFO_DEPTH) begin
          q.push_back(16'(m_lost * 4096 + m_seq * 256 + m_pavg));
          m_lost = 0;
        end else begin
          m_ovf  = 1;
          m_lost = 1;
        end
        m_seq = m_seq + 4'd1;
      end
      if (bus.VALID && !m_vprev) begin
        m_sum = m_sum + int'(bus.RESULT);
        m_n   = m_n + 1;
        if (m_n == NAVG) begin
          m_pavg = m_sum / NAVG;
          m_sum  = 0;
          m_n    = 0;
          m_pend = 1;
        end
      end
      m_vprev  = bus.VALID;
      m_enprev = en;
    end
  end

  // Monitor: GO properties and per-cycle FIFO comparison against the model
  always @(negedge clk) begin
    logic [15:0] exp_dout;
    if (rstn) begin
      if (bus.GO) begin
        go_total++;
        last_go_cyc = cyc;
        check("go_single_cycle", go_prev, 1'b0);
        if (valid_cyc >= 0) check("go_spacing", cyc - valid_cyc, int'(period) + 1);
        if (adc_left > 0) begin
          go_pending++;
          adc_left--;
        end
      end
      go_prev = bus.GO;
      if (cmp_en) begin
        exp_dout = (q.size() > 0) ? q[0] : 16'h0000;
        n_checks++;
        if (bus.DOUT !== exp_dout || bus.EMPTY !== (q.size() == 0) ||
            bus.FULL !== (q.size() == FIFO_DEPTH) || int'(bus.LEVEL) != q.size() ||
            ovf !== m_ovf) begin
          n_fail++;
          if (n_fail < 20)
            $display("FAIL fifo_model cyc=%0d: DOUT=%h/%h LEVEL=%0d/%0d EMPTY=%b FULL=%b OVF=%b/%b",
                     cyc, bus.DOUT, exp_dout, bus.LEVEL, q.size(), bus.EMPTY, bus.FULL, ovf, m_ovf);
        end
      end
    end else begin
      go_prev = 1'b0;
    end
  end

  // ADC behaviour: answer each GO after adc_lat cycles, hold VALID adc_hold cycles
  initial begin : adc_resp
    bus.VALID  = 1'b0;
    bus.RESULT = '0;
    forever begin
      @(posedge clk); #1;
      if (rstn && go_pending > 0) begin
        go_pending--;
        repeat (adc_lat) begin @(posedge clk); #1; end
        bus.RESULT = RES_W'(adc_vals[adc_idx % adc_n]);
        adc_idx++;
        bus.VALID  = 1'b1;
        valid_cyc  = cyc;
        repeat (adc_hold) begin @(posedge clk); #1; end
        bus.VALID  = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rstn = 1'b0; en = 1'b0;
    tick(3);
    go_pending = 0; adc_left = 0; adc_idx = 0;
    go_total = 0; valid_cyc = -1;
    rstn = 1'b1;
  endtask

  task automatic set_adc(input int a, input int b, input int c, input int d,
                         input int n, input int lat, input int hold, input int conv);
    adc_vals[0] = a; adc_vals[1] = b; adc_vals[2] = c; adc_vals[3] = d;
    adc_n = n; adc_idx = 0; adc_lat = lat; adc_hold = hold; adc_left = conv;
  endtask

  task automatic wait_level(input int lvl, input int budget, input string nm);
    int k = 0;
    while (int'(bus.LEVEL) != lvl && k < budget) begin tick(1); k++; end
    check(nm, bus.LEVEL, lvl);
  endtask

  task automatic wait_go(input int n, input int budget, input string nm);
    int k = 0;
    while (go_total < n && k < budget) begin tick(1); k++; end
    check(nm, go_total, n);
  endtask

  task automatic pop_expect(input logic [15:0] exp, input string nm);
    check(nm, bus.DOUT, exp);
    bus.POP = 1'b1;
    tick(1);
    bus.POP = 1'b0;
  endtask

  initial begin : main
    int k;
    int g;
    bus.POP = 1'b0;
    rstn = 1'b0; en = 1'b1; period = 8'd3;

    // Reset with EN held high
    tick(3);
    check("rst_go",      bus.GO,    1'b0);
    check("rst_empty",   bus.EMPTY, 1'b1);
    check("rst_full",    bus.FULL,  1'b0);
    check("rst_dout",    bus.DOUT,  16'h0000);
    check("rst_level",   bus.LEVEL, 0);
    check("rst_ovf",     ovf,       1'b0);
    check("rst_timeout", timeout,   1'b0);
    en = 1'b0; rstn = 1'b1; cmp_en = 1'b1;
    tick(50);
    check("idle_no_go", go_total, 0);

    // Basic average: (5+6+7+9)>>2 = 6, seq 0
    set_adc(5, 6, 7, 9, 4, 1, 1, 4);
    en = 1'b1;
    wait_level(1, 200, "avg_level");
    check("avg_go_count", go_total, 4);
    pop_expect(16'h0006, "avg_dout");
    en = 1'b0;
    tick(10);

    // VALID held high for 10 cycles counts once per conversion
    do_reset();
    set_adc(31, 31, 31, 31, 1, 2, 10, 4);
    en = 1'b1;
    wait_level(1, 400, "hold_level");
    check("hold_go_count", go_total, 4);
    pop_expect(16'h001F, "hold_dout");
    en = 1'b0;
    tick(5);

    // Overflow: six averages, two dropped
    do_reset();
    set_adc(5, 6, 7, 9, 4, 0, 1, 24);
    en = 1'b1;
    k = 0;
    while (m_seq != 4'd6 && k < 600) begin tick(1); k++; end
    check("ovf_six_pushes", m_seq, 4'd6);
    check("ovf_full",  bus.FULL,  1'b1);
    check("ovf_flag",  ovf,       1'b1);
    check("ovf_level", bus.LEVEL, 4);
    pop_expect(16'h0006, "ovf_word0");
    pop_expect(16'h0106, "ovf_word1");
    pop_expect(16'h0206, "ovf_word2");
    pop_expect(16'h0306, "ovf_word3");
    check("ovf_drained", bus.EMPTY, 1'b1);
    adc_left = 3; go_pending = 1;
    wait_level(1, 200, "ovf_next_level");
    pop_expect(16'h1606, "ovf_lost_word");
    check("ovf_still_set", ovf, 1'b1);
    en = 1'b0;
    tick(5);

    // Push and pop in the same cycle while full
    do_reset();
    set_adc(5, 6, 7, 9, 4, 0, 1, 20);
    en = 1'b1;
    k = 0;
    while (!(m_pend && m_seq == 4'd4) && k < 600) begin tick(1); k++; end
    check("pp_reached_fifth", m_seq, 4'd4);
    check("pp_full_before", bus.FULL, 1'b1);
    bus.POP = 1'b1;
    tick(1);
    bus.POP = 1'b0;
    check("pp_level",   bus.LEVEL, 4);
    check("pp_no_ovf",  ovf,       1'b0);
    pop_expect(16'h0106, "pp_word1");
    pop_expect(16'h0206, "pp_word2");
    pop_expect(16'h0306, "pp_word3");
    pop_expect(16'h0406, "pp_tail_word");
    bus.POP = 1'b1;
    tick(1);
    bus.POP = 1'b0;
    tick(1);
    check("pop_empty_level", bus.LEVEL, 0);
    check("pop_empty_flag",  bus.EMPTY, 1'b1);
    check("pop_empty_dout",  bus.DOUT,  16'h0000);
    en = 1'b0;
    tick(5);

    // EN dropped during a conversion: sample still counts, controller idles
    do_reset();
    set_adc(20, 20, 20, 20, 1, 3, 1, 1);
    en = 1'b1;
    wait_go(1, 50, "endrop_first_go");
    en = 1'b0;
    tick(40);
    check("endrop_no_go", go_total, 1);
    check("endrop_no_push", bus.LEVEL, 0);
    set_adc(4, 4, 4, 4, 1, 1, 1, 3);
    valid_cyc = -1;
    en = 1'b1;
    wait_level(1, 200, "endrop_level");
    pop_expect(16'h0008, "endrop_partial_kept");
    en = 1'b0;
    tick(5);

    // Conversion with no VALID
    do_reset();
    set_adc(0, 0, 0, 0, 1, 0, 1, 0);
    en = 1'b1;
    wait_go(1, 50, "to_first_go");
    g = last_go_cyc;
`ifdef SAR_VALID_TIMEOUT_EN
    k = 0;
    while (cyc < g + 1023 && k < 1200) begin tick(1); k++; end
    check("to_before_limit", timeout, 1'b0);
    tick(1);
    check("to_flag", timeout, 1'b1);
    wait_go(2, 20, "to_rego");
    check("to_rego_cycle", last_go_cyc - g, 1027);
    check("to_no_push", bus.LEVEL, 0);
`else
    tick(1100);
    check("to_disabled_flag", timeout, 1'b0);
    check("to_disabled_wait", go_total, 1);
    check("to_no_push", bus.LEVEL, 0);
`endif
    en = 1'b0;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sar_result_avg.md
Name: sar_result_avg

Overview:
- Sits directly downstream of the SAR ADC macro, on the same digital clock as the ADC.
- Generates periodic GO conversion triggers and captures each RESULT on VALID.
- Averages 2^AVG_LOG2 consecutive conversions and pushes tagged averaged words into a small FIFO.
- The SPI read-data path pops words from the FIFO, which decouples conversion rate from host polling rate.

Parameters:
- RES_W, 5, ADC result width.
- AVG_LOG2, 2, log2 of samples per average (0 = no averaging).
- FIFO_DEPTH, 4, FIFO entries (power of 2, >=2).
- PERIOD_W, 8, width of the trigger period register.

Ports:
- CLK  in  1  single clock; ADC control and SPI-side logic share it.
- RSTN  in  1  synchronous active-low reset.
- EN  in  1  run enable for auto-triggering.
- PERIOD  in  PERIOD_W  idle cycles between VALID and next GO.
- GO  out  1  one-cycle conversion start to ADC.
- VALID  in  1  ADC conversion-done (level or pulse).
- RESULT  in  RES_W  ADC code, stable while VALID=1.
- POP  in  1  one-cycle read strobe from SPI side.
- DOUT  out  16  FIFO head word.
- EMPTY  out  1  FIFO empty.
- FULL  out  1  FIFO full.
- LEVEL  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- OVF  out  1  sticky: a word was dropped.
- TIMEOUT  out  1  sticky watchdog flag (see Optional Feature).

Behaviour:
- Reset (RSTN=0 at a CLK edge):
  - Outputs: GO=0, DOUT=0, EMPTY=1, FULL=0, LEVEL=0, OVF=0, TIMEOUT=0.
  - Internal: FSM=IDLE; accumulator, sample count and sequence counter cleared; FIFO flushed.
  - Reset mid-conversion discards the partial average.
- VALID edge detection:
  - VALID is registered; accept = VALID & ~VALID_q (rising edge).
  - A level held high counts once.
- FSM states and transitions:
  - IDLE:
    - EN=1 -> WAIT, load timer=PERIOD.
    - On this IDLE->WAIT transition, OVF and TIMEOUT clear.
  - WAIT:
    - EN=0 -> IDLE.
    - timer==0 -> GO=1 for exactly one cycle, -> CONV.
    - Otherwise timer decrements.
    - PERIOD=0 gives GO in the first WAIT cycle.
  - CONV:
    - accept -> add RESULT to accumulator, increment sample count.
    - Then -> WAIT with timer=PERIOD if EN=1, else -> IDLE.
    - EN falling in CONV does not abort; the in-flight conversion is still accepted.
  - accept outside CONV is ignored.
- Averaging:
  - Accumulator width is RES_W+AVG_LOG2; no overflow is possible.
  - When sample count reaches 2^AVG_LOG2, avg = acc >> AVG_LOG2 (truncate).
  - In the same cycle as that push, acc=0 and count=0.
  - A push occurs one cycle after the final accept.
  - Partial averages persist across EN low/high; only reset clears them.
- Word format:
  - DOUT[RES_W-1:0] = avg.
  - [11:8] = seq, a 4-bit push counter that wraps 15->0 and increments on every attempted push, including dropped ones.
  - [12] = lost: at least one word was dropped since the previously stored word.
  - All other bits are 0.
- FIFO:
  - Behaviour is first-word-fall-through; DOUT=head when !EMPTY, 0 when EMPTY.
  - Push while FULL without POP: word dropped, OVF<=1, lost pending for the next stored word.
  - Push and POP in the same cycle while FULL: both succeed; LEVEL unchanged.
  - POP while EMPTY: ignored.
  - LEVEL, EMPTY and FULL update the cycle after push/pop.

Optional Feature:
- Macro: SAR_VALID_TIMEOUT_EN.
- Defined:
  - A 10-bit counter runs in CONV.
  - If 1023 cycles pass without accept: TIMEOUT<=1 (sticky), discard nothing already accumulated, FSM -> WAIT (or IDLE if EN=0), no push.
  - A late VALID arriving after the abort is ignored unless the FSM is back in CONV.
- Undefined: no counter; CONV waits indefinitely; TIMEOUT tied 0.

Decomposition:
- Shared package sar_avg_pkg:
  - FSM state enum {IDLE, WAIT, CONV}.
  - DOUT field constants: SEQ_LSB=8, SEQ_W=4, LOST_BIT=12.
  - Timeout limit constant 1023.
- Sub-module sar_result_fifo:
  - Synchronous FWFT FIFO, parameterised width/depth.
  - Ports CLK, RSTN, push, din, pop, dout, empty, full, level.
  - Drop-on-full and the lost/OVF logic stay in the parent.

Test Plan:
- Reset/idle: hold RSTN=0 3 cycles with EN=1 -> GO=0, EMPTY=1, DOUT=0x0000, LEVEL=0; release with EN=0 -> no GO for 50 cycles.
- Averaging: EN=1, PERIOD=3, AVG_LOG2=2, ADC model returns 5,6,7,9 -> GO spacing 4 cycles after each VALID edge; one push; DOUT=0x0006 (27>>2), seq=0.
- Level-held VALID: VALID high for 10 cycles with RESULT=31, four conversions -> each counts once; DOUT[4:0]=31.
- Overflow: produce 6 averages with no POP (FIFO_DEPTH=4) -> FULL=1, OVF=1, LEVEL=4; pop 4 -> seq 0,1,2,3 with lost=0; next stored word seq=6 with lost=1 (DOUT bit12=1).
- Simultaneous push+pop when FULL: assert POP on the push cycle -> LEVEL stays 4, OVF stays 0, new word appears at tail; POP on EMPTY -> no change.
- EN drop mid-CONV and timeout: deassert EN after GO -> VALID still accepted, FSM ends in IDLE; with SAR_VALID_TIMEOUT_EN and no VALID -> TIMEOUT=1 at cycle 1023 of CONV, no push, next GO after PERIOD.
